// File: rtl/mult_eval_pkg.sv
// Shared types and sizing helpers for the multiplier evaluation benches.
package mult_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int SETTLE_CNT_W = 4;

    function automatic int n_vectors(input int w);
        return 1 << (2 * w);
    endfunction

    function automatic int err_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mult_sweep_checker_if.sv
// Signals between the sweep checker and its environment (control, results, multiplier under test).
interface mult_sweep_checker_if #(parameter int W = 2);
    import mult_eval_pkg::*;

    logic                   start;
    logic [W-1:0]           dut_a;
    logic [W-1:0]           dut_b;
    logic [2*W-1:0]         dut_p;
    logic                   busy;
    logic                   done;
    logic [err_w(W)-1:0]    err_count;
    logic                   first_err_valid;
    logic [W-1:0]           first_err_a;
    logic [W-1:0]           first_err_b;
    logic [2*W-1:0]         first_err_p;

    modport master (
        input  start, dut_p,
        output dut_a, dut_b, busy, done, err_count,
               first_err_valid, first_err_a, first_err_b, first_err_p
    );

    modport slave (
        output start, dut_p,
        input  dut_a, dut_b, busy, done, err_count,
               first_err_valid, first_err_a, first_err_b, first_err_p
    );

endinterface

// File: rtl/mult_golden.sv
// Behavioural W x W unsigned product, full 2W-bit result.
module mult_golden #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/mult_sweep_checker.sv
// Exhaustive operand sweep around a combinational multiplier; counts mismatches
// against the golden product and captures the first failing vector.
module mult_sweep_checker
    import mult_eval_pkg::*;
#(
    parameter int W      = 2,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_sweep_checker_if.master bus
);

    localparam int VW = 2 * W;
    localparam int EW = err_w(W);
    localparam logic [VW-1:0] VEC_LAST = VW'(n_vectors(W) - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
        (SETTLE > 0) ? SETTLE_CNT_W'(SETTLE - 1) : '0;
    localparam state_e ST_VEC_FIRST = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

    state_e                    state_q, state_d;
    logic [VW-1:0]             vec_q, vec_d;
    logic [SETTLE_CNT_W-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]             err_q, err_d;
    logic                      fev_q, fev_d;
    logic [W-1:0]              fea_q, fea_d;
    logic [W-1:0]              feb_q, feb_d;
    logic [VW-1:0]             fep_q, fep_d;
    logic [VW-1:0]             golden;
    logic                      mismatch;

    // {A, B} sweep counter: B is the low half so B runs fastest.
    mult_golden #(.W(W)) u_golden (
        .a (vec_q[VW-1:W]),
        .b (vec_q[W-1:0]),
        .p (golden)
    );

    assign mismatch = (bus.dut_p != golden);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fea_d   = fea_q;
        feb_d   = feb_q;
        fep_d   = fep_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fea_d   = '0;
                    feb_d   = '0;
                    fep_d   = '0;
                    state_d = ST_VEC_FIRST;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + EW'(1);
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fea_d = vec_q[VW-1:W];
                        feb_d = vec_q[W-1:0];
                        fep_d = bus.dut_p;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + VW'(1);
                    cnt_d   = '0;
                    state_d = ST_VEC_FIRST;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fea_q   <= '0;
            feb_q   <= '0;
            fep_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fea_q   <= fea_d;
            feb_q   <= feb_d;
            fep_q   <= fep_d;
        end
    end

    assign bus.dut_a           = vec_q[VW-1:W];
    assign bus.dut_b           = vec_q[W-1:0];
    assign bus.busy            = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done            = (state_q == ST_DONE);
    assign bus.err_count       = err_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_a     = fea_q;
    assign bus.first_err_b     = feb_q;
    assign bus.first_err_p     = fep_q;

endmodule

// File: doc/mult_sweep_checker.md
# mult_sweep_checker

Sequential exhaustive-sweep checker placed directly around a combinational multiplier under evaluation. It drives every operand pair (A, B) into the multiplier's inputs and samples the multiplier's product. Each sample is compared against a behavioural golden product, and the checker reports the mismatch count and the first failing vector. It is the scoring stage used to accept or reject each generated multiplier architecture during design-space exploration.

## Interface
- W, default 2: operand width; the multiplier product is 2W bits.
- SETTLE, default 0: extra idle cycles after operands change, before the product is sampled (0..15). Non-zero values are for gate-level or timing-annotated sims.
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request a sweep; sampled only in IDLE.
- dut_a  out  W: operand A driven to the multiplier; registered.
- dut_b  out  W: operand B driven to the multiplier; registered.
- dut_p  in  2W: product returned by the multiplier (combinational path from dut_a/dut_b).
- busy  out  1: high while a sweep is in progress.
- done  out  1: one-cycle pulse when a sweep completes.
- err_count  out  2W+1: number of mismatching vectors in the last sweep.
- first_err_valid  out  1: at least one mismatch was captured.
- first_err_a  out  W: A of the first mismatching vector.
- first_err_b  out  W: B of the first mismatching vector.
- first_err_p  out  2W: dut_p observed at the first mismatch.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1, clear err_count and all first_err_* outputs, and load dut_a=0, dut_b=0.
  - Go to SETTLE if SETTLE>0, else go to SAMPLE.
- SETTLE:
  - Count SETTLE cycles, with operands held stable, then go to SAMPLE.
- SAMPLE (one cycle per vector):
  - Compare dut_p against golden = zero-extended dut_a × zero-extended dut_b, both computed at 2W bits.
  - On mismatch, err_count increments, saturating at all-ones; saturation is unreachable for legal W.
  - On the first mismatch, and only while first_err_valid=0, capture dut_a, dut_b and dut_p, and set first_err_valid=1.
- Vector advance:
  - {dut_a, dut_b} is a 2W-bit counter with dut_b as the low part, so the order is A=0,B=0..max, then A=1, and so on.
  - If the counter is not all-ones, increment it and go to SETTLE or SAMPLE as above.
  - Otherwise go to DONE.
- DONE:
  - done=1 for exactly this cycle, then go to IDLE.
- Result retention: results hold their values until the next accepted start or reset.
- start while busy, or in the DONE cycle, is ignored (not queued).
- rst at any time, including mid-sweep, forces IDLE. Every output resets to 0: dut_a, dut_b, busy, done, err_count, first_err_valid, first_err_a, first_err_b, first_err_p.

## Timing
- Let start=1 be seen in cycle 0 while in IDLE.
- busy runs from cycle 1 through the last SAMPLE cycle. busy=0 in DONE and IDLE.
- Each vector occupies SETTLE+1 cycles.
- Total sweep: 2^(2W) × (SETTLE+1) cycles of busy. done is asserted in cycle 1 + 2^(2W) × (SETTLE+1).
  - W=2, SETTLE=0: done in cycle 17.
  - W=2, SETTLE=2: done in cycle 49.
- Operands change only on the edge leaving SAMPLE. dut_p is therefore stable for the full SETTLE window plus the SAMPLE cycle.
- err_count and first_err_* update on the edge ending SAMPLE. Final values are visible in the done cycle.
- Back-to-back sweeps: start is accepted no earlier than the cycle after done.

## Structure
- Shared package mult_eval_pkg holds:
  - the state enum;
  - a function n_vectors(W) = 2^(2W);
  - a function err_w(W) = 2W+1.
- One sub-module, mult_golden, computes the W×W behavioural product (pure combinational, 2W-bit output). It is reused by other evaluation benches.
- The DUT is instantiated outside this block. The checker only sees dut_a, dut_b and dut_p.

## Test plan
- Reset: assert rst with a sweep running mid-way -> all outputs 0 on the next cycle. A start two cycles later gives a full, clean sweep.
- Correct DUT, W=2, SETTLE=0: start in cycle 0 -> busy in cycles 1–16, done in cycle 17, err_count=0, first_err_valid=0.
- Faulty DUT, W=2, missing the A[1]&B[0] partial product -> err_count=4, first_err_a=2, first_err_b=1, first_err_p=0.
- SETTLE=2 with a correct DUT -> each operand pair is held 3 cycles and done arrives in cycle 49. The DUT output is delayed 2 cycles by the bench, and this still gives err_count=0.
- start pulsed during busy and in the done cycle -> ignored: no restart and no counter clear. The results of the first sweep are unchanged.
- W=3 stuck-at-0 product (all-zero DUT) -> 64 vectors, done in cycle 65, err_count=49, first_err_a=1, first_err_b=1.
